// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD counter and its decade cells.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'd0;

  // Map out-of-range nibbles (10-15) to 9 so stored digits stay decimal.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: holds a 0-9 digit, steps up/down on step_in, forwards carry/borrow.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_d,
  input  logic               step_in,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               step_out
);

  logic [DIGIT_W-1:0] q_next;
  logic               at_limit;

  // A digit is terminal at 9 when counting up and at 0 when counting down.
  assign at_limit = up ? (q == DIGIT_MAX) : (q == DIGIT_MIN);
  assign step_out = step_in & at_limit;

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = clamp_digit(load_d);
    end else if (step_in) begin
      if (up) begin
        q_next = at_limit ? DIGIT_MIN : DIGIT_W'(q + DIGIT_W'(1));
      end else begin
        q_next = at_limit ? DIGIT_MAX : DIGIT_W'(q - DIGIT_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= DIGIT_MIN;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with load, terminal count and a registered wrap pulse.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      en,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      tc,
  output logic                      wrap
);

  // step[i] is the carry/borrow entering digit i; step[DIGITS] leaves the top digit.
  logic [DIGITS:0] step;

  assign step[0] = en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .clear    (clear),
      .load     (load),
      .load_d   (load_val[DIGIT_W*i +: DIGIT_W]),
      .step_in  (step[i]),
      .up       (up),
      .q        (count[DIGIT_W*i +: DIGIT_W]),
      .step_out (step[i+1])
    );
  end

  assign tc = step[DIGITS];

  // A carry out of the top digit on a plain step edge is a wrap.
  always_ff @(posedge clk) begin
    if (clear) begin
      wrap <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
    end else begin
      wrap <= step[DIGITS];
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter (DIGITS=4) against an integer reference model.
module tb_bcd_counter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
  localparam int          MOD    = 10000;

  logic         clk = 1'b0;
  logic         clear, en, up, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, wrap;

  int   errors = 0;
  int   checks = 0;
  int   m_val  = 0;
  logic m_wrap = 1'b0;

  always #5 clk = ~clk;

  bcd_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_to_int(input logic [W-1:0] lv);
    int         v;
    logic [3:0] d;
    v = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      d = lv[4*i +: 4];
      v = v * 10 + ((d > 4'd9) ? 9 : int'(d));
    end
    return v;
  endfunction

  function automatic logic exp_tc();
    return en && (up ? (m_val == MOD - 1) : (m_val == 0));
  endfunction

  // Advance the model by one edge from the current inputs, then let the DUT take the edge.
  task automatic tick();
    if (clear) begin
      m_val = 0; m_wrap = 1'b0;
    end else if (load) begin
      m_val = load_to_int(load_val); m_wrap = 1'b0;
    end else if (en) begin
      if (up) begin
        m_wrap = (m_val == MOD - 1); m_val = (m_val + 1) % MOD;
      end else begin
        m_wrap = (m_val == 0); m_val = (m_val + MOD - 1) % MOD;
      end
    end else begin
      m_wrap = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    tick(); tick();
    clear = 1'b0;
    do_load(16'h0357);
    checks++; if (count !== 16'h0357) begin errors++; $display("FAIL reset_preload count got %h want 0357", count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (count !== 16'h0000) begin errors++; $display("FAIL reset count got %h want 0000", count); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset wrap got %b want 0", wrap); end
    en = 1'b1; up = 1'b0; #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset tc got %b want 1", tc); end
    en = 1'b0;
  endtask

  task automatic test_up_carry();
    logic [W-1:0] want [2];
    want[0] = 16'h0200; want[1] = 16'h0201;
    do_load(16'h0199);
    en = 1'b1; up = 1'b1; #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_carry tc0 got %b want 0", tc); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (count !== want[i]) begin errors++; $display("FAIL up_carry count[%0d] got %h want %h", i, count, want[i]); end
      checks++; if (tc !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL up_carry tc/wrap[%0d] got %b/%b want 0/0", i, tc, wrap); end
    end
    en = 1'b0;
  endtask

  task automatic test_up_wrap();
    do_load(16'h9998);
    en = 1'b1; up = 1'b1;
    tick();
    checks++; if (count !== 16'h9999 || tc !== 1'b1) begin errors++; $display("FAIL up_wrap pre count/tc got %h/%b want 9999/1", count, tc); end
    tick();
    checks++; if (count !== 16'h0000 || wrap !== 1'b1) begin errors++; $display("FAIL up_wrap edge count/wrap got %h/%b want 0000/1", count, wrap); end
    tick();
    checks++; if (wrap !== 1'b0 || count !== 16'h0001) begin errors++; $display("FAIL up_wrap after count/wrap got %h/%b want 0001/0", count, wrap); end
    en = 1'b0;
  endtask

  task automatic test_down();
    do_load(16'h1000);
    en = 1'b1; up = 1'b0;
    tick();
    checks++; if (count !== 16'h0999) begin errors++; $display("FAIL down_borrow count got %h want 0999", count); end
    load = 1'b1; load_val = 16'h0000;
    tick();
    load = 1'b0; #1;
    checks++; if (count !== 16'h0000 || tc !== 1'b1) begin errors++; $display("FAIL down_tc count/tc got %h/%b want 0000/1", count, tc); end
    tick();
    checks++; if (count !== 16'h9999 || wrap !== 1'b1) begin errors++; $display("FAIL down_wrap count/wrap got %h/%b want 9999/1", count, wrap); end
    en = 1'b0;
  endtask

  task automatic test_priority();
    load = 1'b1; en = 1'b1; up = 1'b1; load_val = 16'hAF35;
    tick();
    checks++; if (count !== 16'h9935 || wrap !== 1'b0) begin errors++; $display("FAIL prio_clamp count/wrap got %h/%b want 9935/0", count, wrap); end
    clear = 1'b1;
    tick();
    clear = 1'b0; load = 1'b0; en = 1'b0;
    checks++; if (count !== 16'h0000) begin errors++; $display("FAIL prio_clear count got %h want 0000", count); end
  endtask

  task automatic test_hold_dir();
    do_load(16'h0042);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = 1'($urandom_range(0, 1));
      tick();
      checks++; if (count !== 16'h0042 || wrap !== 1'b0) begin errors++; $display("FAIL hold[%0d] count/wrap got %h/%b want 0042/0", i, count, wrap); end
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up = (i % 2 == 0);
      tick();
      checks++; if (count !== ((i % 2 == 0) ? 16'h0043 : 16'h0042)) begin errors++; $display("FAIL dir_change[%0d] count got %h", i, count); end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    do_load(to_bcd(int'($urandom_range(0, MOD - 1))));
    for (int i = 0; i < 600; i++) begin
      clear    = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 9) < 8);
      up       = 1'($urandom_range(0, 1));
      // Bias some loads to the terminal values so wraps are exercised often.
      case ($urandom_range(0, 3))
        0:       load_val = 16'h9999;
        1:       load_val = 16'h0000;
        default: load_val = W'($urandom);
      endcase
      #1;
      checks++; if (tc !== exp_tc()) begin errors++; $display("FAIL rand_tc[%0d] got %b want %b", i, tc, exp_tc()); end
      tick();
      checks++; if (count !== to_bcd(m_val) || wrap !== m_wrap) begin
        errors++; $display("FAIL rand_state[%0d] count/wrap got %h/%b want %h/%b", i, count, wrap, to_bcd(m_val), m_wrap);
      end
    end
    clear = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_long_wrap();
    int first_wrap;
    int n_wraps;
    clear = 1'b1; tick(); clear = 1'b0;
    en = 1'b1; up = 1'b1;
    first_wrap = -1; n_wraps = 0;
    for (int i = 1; i <= MOD + 5; i++) begin
      tick();
      if (wrap === 1'b1) begin
        n_wraps++;
        if (first_wrap < 0) first_wrap = i;
      end
    end
    en = 1'b0;
    checks++; if (first_wrap !== MOD || n_wraps !== 1) begin
      errors++; $display("FAIL long_wrap first/count got %0d/%0d want %0d/1", first_wrap, n_wraps, MOD);
    end
    checks++; if (count !== to_bcd(5)) begin errors++; $display("FAIL long_wrap count got %h want 0005", count); end
  endtask

  initial begin
    test_reset();
    test_up_carry();
    test_up_wrap();
    test_down();
    test_priority();
    test_hold_dir();
    test_random();
    test_long_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
